// File: rtl/ddram_arb_pkg.sv
// Shared types and constants for the DDR3 port arbiter.
package ddram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WBEATS,
        RBEATS
    } arb_state_t;

    localparam int BURST_W   = 8;
    localparam int MAX_PORTS = 4;

    // A burst count of zero behaves like a single-beat burst.
    function automatic logic [BURST_W-1:0] burst_len(input logic [BURST_W-1:0] cnt);
        return (cnt == '0) ? BURST_W'(1) : cnt;
    endfunction

endpackage

// File: rtl/ddram_arb_pick.sv
// Combinational grant picker. DDRAM_ARB_ROUND_ROBIN_EN selects round-robin,
// otherwise fixed priority with the lowest port index winning.
module ddram_arb_pick
    import ddram_arb_pkg::*;
#(
    parameter int NPORTS = 3
) (
    input  logic [NPORTS-1:0] req,
    input  logic [NPORTS-1:0] last,
    output logic [NPORTS-1:0] pick
);

`ifdef DDRAM_ARB_ROUND_ROBIN_EN
    int   last_idx;
    int   idx;
    logic found;

    // Search begins at the port just after the previous owner.
    always_comb begin
        pick     = '0;
        found    = 1'b0;
        last_idx = NPORTS - 1;
        idx      = 0;
        for (int i = 0; i < NPORTS; i++) begin
            if (last[i]) last_idx = i;
        end
        for (int off = 1; off <= NPORTS; off++) begin
            idx = (last_idx + off) % NPORTS;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        pick = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ddram_arbiter.sv
// Shares one 64-bit DDR3 slave port between NPORTS Avalon-style masters.
// Define DDRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).
module ddram_arbiter
    import ddram_arb_pkg::*;
#(
    parameter int ADDRBITS = 24,
    parameter int NPORTS   = 3
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [NPORTS*(ADDRBITS+1)-1:0] REQ_ADDR,
    input  logic [NPORTS*64-1:0]           REQ_DIN,
    input  logic [NPORTS*8-1:0]            REQ_BE,
    input  logic [NPORTS*8-1:0]            REQ_BURSTCNT,
    input  logic [NPORTS-1:0]              REQ_RD,
    input  logic [NPORTS-1:0]              REQ_WE,
    output logic [NPORTS-1:0]              REQ_BUSY,
    output logic [63:0]                    REQ_DOUT,
    output logic [NPORTS-1:0]              REQ_DOUT_READY,
    output logic [ADDRBITS:0]              DDRAM_ADDR,
    output logic [63:0]                    DDRAM_DIN,
    output logic [7:0]                     DDRAM_BE,
    output logic [7:0]                     DDRAM_BURSTCNT,
    output logic                           DDRAM_RD,
    output logic                           DDRAM_WE,
    input  logic [63:0]                    DDRAM_DOUT,
    input  logic                           DDRAM_DOUT_READY,
    input  logic                           DDRAM_BUSY,
    output logic [NPORTS-1:0]              ARB_GNT
);

    localparam int AW = ADDRBITS + 1;

    if (NPORTS < 2 || NPORTS > MAX_PORTS) begin : g_bad_nports
        $error("ddram_arbiter: NPORTS out of range");
    end

    arb_state_t         state, state_n;
    logic [NPORTS-1:0]  gnt, gnt_n;
    logic [NPORTS-1:0]  pick;
    logic [NPORTS-1:0]  last_gnt;
    logic [BURST_W-1:0] beats, beats_n;

    logic [AW-1:0]      g_addr;
    logic [63:0]        g_din;
    logic [7:0]         g_be;
    logic [BURST_W-1:0] g_bcnt;
    logic               g_rd, g_we;

    // One-hot mux of the owning port's command slice; all zero when idle.
    always_comb begin
        g_addr = '0;
        g_din  = '0;
        g_be   = '0;
        g_bcnt = '0;
        for (int n = 0; n < NPORTS; n++) begin
            if (gnt[n]) begin
                g_addr = REQ_ADDR[n*AW +: AW];
                g_din  = REQ_DIN[n*64 +: 64];
                g_be   = REQ_BE[n*8 +: 8];
                g_bcnt = REQ_BURSTCNT[n*8 +: 8];
            end
        end
    end

    assign g_rd = |(REQ_RD & gnt);
    assign g_we = |(REQ_WE & gnt);

`ifdef DDRAM_ARB_ROUND_ROBIN_EN
    logic [NPORTS-1:0] last_q;

    // Reset to the top port so the first search starts at port 0.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            last_q <= {1'b1, {(NPORTS-1){1'b0}}};
        else if (state == IDLE && |pick)
            last_q <= pick;
    end
    assign last_gnt = last_q;
`else
    assign last_gnt = '0;
`endif

    ddram_arb_pick #(
        .NPORTS(NPORTS)
    ) u_pick (
        .req (REQ_RD | REQ_WE),
        .last(last_gnt),
        .pick(pick)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            gnt   <= '0;
            beats <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            beats <= beats_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        beats_n = beats;
        case (state)
            IDLE: begin
                if (|pick) begin
                    gnt_n   = pick;
                    state_n = CMD;
                end
            end
            CMD: begin
                // RD takes precedence when a port raises both strobes.
                if (g_rd && !DDRAM_BUSY) begin
                    beats_n = burst_len(g_bcnt);
                    state_n = RBEATS;
                end else if (g_we && !DDRAM_BUSY) begin
                    beats_n = burst_len(g_bcnt) - BURST_W'(1);
                    if (beats_n == '0) begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end else begin
                        state_n = WBEATS;
                    end
                end else if (!g_rd && !g_we) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                end
            end
            WBEATS: begin
                if (g_we && !DDRAM_BUSY) begin
                    beats_n = beats - BURST_W'(1);
                    if (beats == BURST_W'(1)) begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end
            end
            RBEATS: begin
                if (DDRAM_DOUT_READY) begin
                    beats_n = beats - BURST_W'(1);
                    if (beats == BURST_W'(1)) begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    assign DDRAM_ADDR     = g_addr;
    assign DDRAM_DIN      = g_din;
    assign DDRAM_BE       = g_be;
    assign DDRAM_BURSTCNT = g_bcnt;
    assign DDRAM_RD       = (state == CMD) & g_rd;
    assign DDRAM_WE       = ((state == CMD) & g_we & ~g_rd) | ((state == WBEATS) & g_we);

    assign REQ_BUSY       = ~gnt | {NPORTS{DDRAM_BUSY | (state == RBEATS)}};
    assign REQ_DOUT       = DDRAM_DOUT;
    // Read data outside RBEATS is stray and never reaches a master.
    assign REQ_DOUT_READY = gnt & {NPORTS{(state == RBEATS) & DDRAM_DOUT_READY}};
    assign ARB_GNT        = gnt;

endmodule
